// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: instruction layout, FSM states,
// flag indices and the opcode set understood by the downstream ALU.
package alu_seq_pkg;

  localparam int INSTR_W = 16;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int WE_BIT  = 12;
  localparam int ADDR_HI = 11;
  localparam int ADDR_LO = 8;
  localparam int A_HI    = 7;
  localparam int A_LO    = 4;
  localparam int B_HI    = 3;
  localparam int B_LO    = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  function automatic logic is_write(input logic [INSTR_W-1:0] instr);
    return instr[WE_BIT];
  endfunction

endpackage

// File: rtl/alu_issue_seq_fifo.sv
// seq_fifo: DEPTH x 16 synchronous instruction FIFO with show-ahead head word,
// full/empty flags and synchronous active-low reset.
module seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] wdata,
  output logic [INSTR_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic               do_push;
  logic               do_pop;

  // full/empty come from the registered count, so a same-cycle pop never frees room
  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer feeding the 4-bit ALU/register-file stage, one instruction in flight.
// Optional feature macro: ALU_SEQ_STICKY_FLAGS_EN (sticky_clr input, sticky_flags output).
module alu_issue_seq
  import alu_seq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_opcode,
  output logic [3:0]  alu_addr,
  output logic        alu_write_en,
  input  logic [3:0]  alu_result,
  input  logic [3:0]  alu_mem_out,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_neg,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [3:0]  resp_data,
  output logic [2:0]  resp_flags,
  output logic        resp_kind,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  input  logic        sticky_clr,
  output logic [2:0]  sticky_flags,
`endif
  output logic        busy
);

  localparam int WCW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  state_t         state_reg, state_next;
  logic           pop;
  logic           capture;
  logic           full;
  logic           empty;
  logic [15:0]    head;
  logic [2:0]     alu_flags;
  logic [WCW-1:0] wait_cnt_reg;

  logic [3:0] alu_a_reg, alu_b_reg, alu_addr_reg;
  logic [2:0] alu_opcode_reg;
  logic       write_en_reg;
  logic       cur_we_reg;
  logic       resp_valid_reg;
  logic [3:0] resp_data_reg;
  logic [2:0] resp_flags_reg;
  logic       resp_kind_reg;

  assign in_ready = !full && rst;

  seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata (in_instr),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign alu_flags[FLAG_ZERO]  = alu_zero;
  assign alu_flags[FLAG_CARRY] = alu_carry;
  assign alu_flags[FLAG_NEG]   = alu_neg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (wait_cnt_reg == WCW'(RESP_LAT - 1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_valid_reg && resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU drive registers load only on pop, so they hold through capture and beyond
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_opcode_reg <= '0;
      alu_addr_reg   <= '0;
      write_en_reg   <= 1'b0;
      cur_we_reg     <= 1'b0;
      wait_cnt_reg   <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_flags_reg <= '0;
      resp_kind_reg  <= 1'b0;
    end else begin
      write_en_reg <= pop && is_write(head);
      if (pop) begin
        alu_a_reg      <= head[A_HI:A_LO];
        alu_b_reg      <= head[B_HI:B_LO];
        alu_opcode_reg <= head[OP_HI:OP_LO];
        alu_addr_reg   <= head[ADDR_HI:ADDR_LO];
        cur_we_reg     <= is_write(head);
      end
      if (state_reg == ISSUE) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + WCW'(1);
      end
      if (capture) begin
        resp_valid_reg <= 1'b1;
        if (cur_we_reg) begin
          resp_data_reg  <= alu_result;
          resp_flags_reg <= alu_flags;
          resp_kind_reg  <= 1'b0;
        end else begin
          resp_data_reg  <= alu_mem_out;
          resp_flags_reg <= '0;
          resp_kind_reg  <= 1'b1;
        end
      end else if (resp_valid_reg && resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic [2:0] sticky_reg;

  // clear takes priority over a flag set captured on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      sticky_reg <= '0;
    end else if (sticky_clr) begin
      sticky_reg <= '0;
    end else if (capture && cur_we_reg) begin
      sticky_reg <= sticky_reg | alu_flags;
    end
  end

  assign sticky_flags = sticky_reg;
`endif

  assign alu_a        = alu_a_reg;
  assign alu_b        = alu_b_reg;
  assign alu_opcode   = alu_opcode_reg;
  assign alu_addr     = alu_addr_reg;
  assign alu_write_en = write_en_reg;
  assign resp_valid   = resp_valid_reg;
  assign resp_data    = resp_data_reg;
  assign resp_flags   = resp_flags_reg;
  assign resp_kind    = resp_kind_reg;
  assign busy         = !empty || (state_reg != IDLE);

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed vector table, corner sequences
// and randomized traffic against an in-order response model.
module tb_alu_issue_seq;
  import alu_seq_pkg::*;

  localparam int DEPTH    = 4;
  localparam int RESP_LAT = 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [3:0]  alu_a, alu_b, alu_addr;
  logic [2:0]  alu_opcode;
  logic        alu_write_en;
  logic [3:0]  alu_result, alu_mem_out;
  logic        alu_zero, alu_carry, alu_neg;
  logic        resp_valid, resp_ready;
  logic [3:0]  resp_data;
  logic [2:0]  resp_flags;
  logic        resp_kind;
  logic        busy;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic        sticky_clr;
  logic [2:0]  sticky_flags;
`endif

  alu_issue_seq #(.DEPTH(DEPTH), .RESP_LAT(RESP_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_addr     (alu_addr),
    .alu_write_en (alu_write_en),
    .alu_result   (alu_result),
    .alu_mem_out  (alu_mem_out),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_neg      (alu_neg),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_flags   (resp_flags),
    .resp_kind    (resp_kind),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Functional ALU: returns {neg, carry, zero, result}
  function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] w;
    logic       c;
    c = 1'b0;
    case (op)
      OP_ADD:  begin w = {1'b0, a} + {1'b0, b}; c = w[4]; end
      OP_SUB:  begin w = {1'b0, a} - {1'b0, b}; c = (a < b); end
      OP_AND:  w = {1'b0, a & b};
      OP_OR:   w = {1'b0, a | b};
      OP_XOR:  w = {1'b0, a ^ b};
      OP_SHL:  begin w = {1'b0, a[2:0], 1'b0}; c = a[3]; end
      OP_SHR:  begin w = {2'b00, a[3:1]}; c = a[0]; end
      default: w = {1'b0, a};
    endcase
    return {w[3], c, (w[3:0] == 4'd0), w[3:0]};
  endfunction

  // Environment: ALU plus a 16-entry register file that resets with the system
  logic [3:0] rf [16];
  assign {alu_neg, alu_carry, alu_zero, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_mem_out = rf[alu_addr];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 4'd0;
    end else if (alu_write_en) begin
      rf[alu_addr] <= alu_result;
    end
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic we, input logic [3:0] addr,
                                     input logic [3:0] a, input logic [3:0] b);
    return {op, we, addr, a, b};
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  data;
    logic [2:0]  flags;
    logic        kind;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_acc    = 0;
  int         n_resp   = 0;
  logic [7:0] exp_q [$];
  logic [3:0] exp_mem [16];
  logic       hold_prev = 1'b0;
  logic [7:0] held;
  logic [7:0] last_resp;
  logic       hs_resp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected response {kind, flags, data}, applying writes in acceptance order
  task automatic model(input logic [15:0] ins, output logic [7:0] e);
    logic [6:0] r;
    if (ins[12]) begin
      r = alu_fn(ins[15:13], ins[7:4], ins[3:0]);
      exp_mem[ins[11:8]] = r[3:0];
      e = {1'b0, r[6:4], r[3:0]};
    end else begin
      e = {1'b1, 3'b000, exp_mem[ins[11:8]]};
    end
  endtask

  // One clock: drive at negedge, then observe handshakes that the next edge will take
  task automatic cycle(input logic r, input logic v, input logic [15:0] ins, input logic rr);
    logic [7:0] e;
    @(negedge clk);
    rst = r; in_valid = v; in_instr = ins; resp_ready = rr;
    #1;
    if (!r) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_mem[i] = 4'd0;
    end
    if (hold_prev) check("resp_hold", {resp_valid, resp_kind, resp_flags, resp_data}, {1'b1, held});
    hold_prev = r && resp_valid && !resp_ready;
    held      = {resp_kind, resp_flags, resp_data};
    hs_resp   = 1'b0;
    if (r && resp_valid && resp_ready) begin
      hs_resp   = 1'b1;
      last_resp = {resp_kind, resp_flags, resp_data};
      n_resp++;
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_order", last_resp, e);
      end
    end
    if (r && v && in_ready) begin
      model(ins, e);
      exp_q.push_back(e);
      n_acc++;
    end
  endtask

  // Single instruction into an idle sequencer, with latency and strobe checks
  task automatic run_one(input vec_t t);
    int         we_cnt, we_at, resp_at;
    logic [3:0] we_addr;
    we_cnt = 0; we_at = -1; resp_at = -1; we_addr = 4'd0;
    cycle(1'b1, 1'b1, t.instr, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0, 16'h0000, 1'b1);
      if (alu_write_en) begin we_cnt++; we_at = k; we_addr = alu_addr; end
      if (hs_resp) begin resp_at = k; break; end
    end
    check("resp_latency", resp_at, RESP_LAT + 2);
    check("we_pulses", we_cnt, {31'd0, t.instr[12]});
    if (t.instr[12]) begin
      check("we_addr", we_addr, t.instr[11:8]);
      check("issue_to_resp", resp_at - we_at, RESP_LAT + 1);
    end
    check("vec_resp", last_resp, {t.kind, t.flags, t.data});
    $display("vec instr %04h resp %02h at cycle %0d", t.instr, last_resp, resp_at);
  endtask

  vec_t tbl [8];
  vec_t sv;
  int   n0, n1;
  logic seen;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_instr = 16'hFFFF; resp_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'd0;

    tbl[0] = '{mk(OP_ADD, 1'b1, 4'd3, 4'd15, 4'd1), 4'd0,  3'b011, 1'b0};
    tbl[1] = '{mk(OP_ADD, 1'b1, 4'd4, 4'd10, 4'd3), 4'd13, 3'b100, 1'b0};
    tbl[2] = '{mk(OP_ADD, 1'b0, 4'd4, 4'd0,  4'd0), 4'd13, 3'b000, 1'b1};
    tbl[3] = '{mk(OP_SUB, 1'b1, 4'd5, 4'd3,  4'd5), 4'd14, 3'b110, 1'b0};
    tbl[4] = '{mk(OP_AND, 1'b1, 4'd6, 4'd12, 4'd10), 4'd8, 3'b100, 1'b0};
    tbl[5] = '{mk(OP_XOR, 1'b1, 4'd7, 4'd9,  4'd9), 4'd0,  3'b001, 1'b0};
    tbl[6] = '{mk(OP_OR,  1'b0, 4'd5, 4'd7,  4'd7), 4'd14, 3'b000, 1'b1};
    tbl[7] = '{mk(OP_SHL, 1'b1, 4'd8, 4'd9,  4'd0), 4'd2,  3'b010, 1'b0};

    // Reset held for two edges with in_valid high
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
    check("reset_outs", {in_ready, alu_a, alu_b, alu_opcode, alu_addr, alu_write_en,
                         resp_valid, resp_data, resp_flags, resp_kind, busy}, 32'd0);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    check("reset_sticky", sticky_flags, 3'b000);
`endif
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
    check("release_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) run_one(tbl[i]);

    // Backpressure: 7 offers with the response channel stalled
    n0 = n_acc;
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
    check("bp_accepted", n_acc - n0, DEPTH + 1);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_first", {resp_valid, resp_kind, resp_flags, resp_data}, {1'b1, exp_q[0]});
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    n1 = n_resp;
    for (int i = 0; i < 40 && (exp_q.size() > 0 || busy); i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check("bp_responses", n_resp - n1, DEPTH + 1);

    // Reset while waiting for the ALU
    cycle(1'b1, 1'b1, mk(OP_ADD, 1'b1, 4'd2, 4'd5, 4'd6), 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 16'h0000, 1'b1);
      if (alu_write_en) begin seen = 1'b1; break; end
    end
    check("midop_issue_seen", seen, 1'b1);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    check("midop_after_reset", {resp_valid, busy, alu_write_en, in_ready}, 4'b0000);
    n1 = n_resp;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check("midop_no_resp", n_resp - n1, 0);
    check("midop_idle", busy, 1'b0);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    check("sticky_after_reset", sticky_flags, 3'b000);
    sv = '{mk(OP_ADD, 1'b1, 4'd1, 4'd9, 4'd8), 4'd1, 3'b010, 1'b0};
    run_one(sv);
    sv = '{mk(OP_OR, 1'b1, 4'd2, 4'd8, 4'd0), 4'd8, 3'b100, 1'b0};
    run_one(sv);
    check("sticky_set", sticky_flags, 3'b110);
    @(negedge clk); sticky_clr = 1'b1;
    @(negedge clk); sticky_clr = 1'b0;
    #1;
    check("sticky_clr", sticky_flags, 3'b000);
`endif

    // Randomized traffic against the in-order model
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 100 && (exp_q.size() > 0 || busy); i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
